// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
//  Module      : instr_fetch_unit_pkg
//  Description : Shared widths, reset PC and fetch FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

    localparam int          c_XLEN     = 32;
    localparam int          c_OP_W     = 7;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [c_XLEN-1:0] align_word(input logic [c_XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Memory, decode and redirect signals of the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [c_XLEN-1:0]   imem_addr;
    logic                imem_rsp_valid;
    logic [c_XLEN-1:0]   imem_rdata;
    logic                if_valid;
    logic                if_ready;
    logic [c_XLEN-1:0]   if_instr;
    logic [c_XLEN-1:0]   if_pc;
    logic [c_OP_W-1:0]   if_op;
    logic                redirect_valid;
    logic [c_XLEN-1:0]   redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_op,
        input  imem_req_ready, imem_rsp_valid, imem_rdata, if_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_op,
        output imem_req_ready, imem_rsp_valid, imem_rdata, if_ready,
               redirect_valid, redirect_pc
    );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH-entry {pc, instr} buffer with flush, full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      i_flush,
    input  wire                      i_push,
    input  wire                      i_pop,
    input  wire  [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW:0]   c_CNT_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : In-order instruction fetch with credit-limited requests,
//                response buffer and redirect flush/drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  wire                 clk,
    input  wire                 reset,
    instr_fetch_unit_if.master  bus
);

    localparam int               c_CW      = $clog2(DEPTH) + 1;
    localparam int               c_OW      = c_CW + 1;
    localparam logic [c_CW-1:0]  c_ONE     = c_CW'(1);
    localparam logic [c_CW-1:0]  c_ZERO    = '0;
    localparam logic [c_OW-1:0]  c_DEPTH_V = c_OW'(DEPTH);
    localparam logic [c_XLEN-1:0] c_PC_STEP = 32'd4;

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [c_XLEN-1:0]   r_fetch_pc;
    logic [c_XLEN-1:0]   r_rsp_pc;
    logic [c_CW-1:0]     r_inflight;
    logic [c_CW-1:0]     r_drop;
    logic [c_CW-1:0]     w_inflight_nxt;
    logic [c_CW-1:0]     w_drop_nxt;
    logic [c_CW-1:0]     w_count;
    logic [c_OW-1:0]     w_occ;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_rsp_acc;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_if_valid;
    logic [2*c_XLEN-1:0] w_head;
    logic [c_XLEN-1:0]   w_instr;
    logic [c_XLEN-1:0]   w_redir_pc;

    // Credits cover both outstanding requests and buffered entries, so a
    // response always finds a free slot.
    assign w_occ       = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_req_valid = !reset && (r_state == ST_RUN) && (w_occ < c_DEPTH_V);
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp_acc   = bus.imem_rsp_valid && (r_inflight != c_ZERO);
    assign w_push      = w_rsp_acc && (r_state == ST_RUN) && !bus.redirect_valid && !w_full;
    assign w_if_valid  = !w_empty;
    assign w_pop       = w_if_valid && bus.if_ready;
    assign w_redir_pc  = align_word(bus.redirect_pc);

    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_req_fire, w_rsp_acc})
            2'b10:   w_inflight_nxt = r_inflight + c_ONE;
            2'b01:   w_inflight_nxt = r_inflight - c_ONE;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    w_drop_nxt = w_inflight_nxt;
                    if (w_inflight_nxt != c_ZERO) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.redirect_valid) begin
                    w_drop_nxt = w_inflight_nxt;
                end else if (w_rsp_acc && (r_drop != c_ZERO)) begin
                    w_drop_nxt = r_drop - c_ONE;
                end
                if (w_drop_nxt == c_ZERO) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_drop     <= w_drop_nxt;
            if (bus.redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                if (w_push)     r_rsp_pc   <= r_rsp_pc + c_PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*c_XLEN)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_rsp_pc, bus.imem_rdata}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_instr            = w_if_valid ? w_head[c_XLEN-1:0] : '0;
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_instr       = w_instr;
    assign bus.if_pc          = w_if_valid ? w_head[2*c_XLEN-1:c_XLEN] : '0;
    assign bus.if_op          = w_instr[c_OP_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Randomized bench for instr_fetch_unit with a stream-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Stream model: expected next decoded pc and next requested pc.
    logic [31:0] exp_pc, exp_req_pc;
    logic [31:0] pq_addr[$];
    int          pq_due[$];
    int          cyc = 0;

    int unsigned p_rdy, p_rsp, p_ifr, p_redir;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt;
    logic        redir_at_en = 1'b0;
    logic [31:0] redir_at_pc, redir_at_tgt;

    int          n_req, n_pop, n_pop_8, n_seen_c, drain_ifv;
    logic [31:0] first_req_addr, last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rdata       = '0;
        bus.if_ready         = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        #1;
        check_eq("rst_if_valid",  32'(bus.if_valid), 32'd0);
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_addr",      bus.imem_addr, RESET_PC);
        check_eq("rst_if_instr",  bus.if_instr, 32'd0);
        check_eq("rst_if_pc",     bus.if_pc, 32'd0);
        check_eq("rst_if_op",     32'(bus.if_op), 32'd0);
        pq_addr.delete();
        pq_due.delete();
        exp_pc     = RESET_PC;
        exp_req_pc = RESET_PC;
        n_req = 0; n_pop = 0; n_pop_8 = 0; n_seen_c = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic step();
        logic        rdy, rsp, ifr, rdr;
        logic [31:0] tgt, w;
        rdy = ($urandom_range(99) < p_rdy);
        rsp = 1'b0;
        if (pq_addr.size() != 0) begin
            if (pq_due[0] <= cyc && $urandom_range(99) < p_rsp) rsp = 1'b1;
        end
        ifr = ($urandom_range(99) < p_ifr);
        rdr = ($urandom_range(999) < p_redir);
        tgt = $urandom;
        if (force_redir) begin
            rdr = 1'b1; tgt = force_tgt; force_redir = 1'b0;
        end
        if (redir_at_en && bus.if_valid && bus.if_pc == redir_at_pc) begin
            rdr = 1'b1; ifr = 1'b1; tgt = redir_at_tgt; redir_at_en = 1'b0;
        end

        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rsp;
        if (rsp) begin
            bus.imem_rdata = mem_word(pq_addr[0]);
            void'(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end else begin
            bus.imem_rdata = $urandom;
        end
        bus.if_ready       = ifr;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = tgt;

        if (bus.imem_req_valid && rdy) begin
            check_eq("req_addr", bus.imem_addr, exp_req_pc);
            if (n_req == 0) first_req_addr = bus.imem_addr;
            pq_addr.push_back(bus.imem_addr);
            pq_due.push_back(cyc + 1);
            n_req++;
            exp_req_pc += 32'd4;
            check_eq("inflight_le_depth", 32'(pq_addr.size() <= DEPTH), 32'd1);
        end
        if (bus.if_valid) begin
            w = mem_word(exp_pc);
            check_eq("if_pc",    bus.if_pc, exp_pc);
            check_eq("if_instr", bus.if_instr, w);
            check_eq("if_op",    32'(bus.if_op), 32'(w[6:0]));
            if (bus.if_pc == 32'hC) n_seen_c++;
            if (ifr) begin
                last_pop_pc = bus.if_pc;
                if (bus.if_pc == 32'h8) n_pop_8++;
                n_pop++;
                exp_pc += 32'd4;
            end
        end
        if (rdr) begin
            exp_pc     = tgt & ~32'h3;
            exp_req_pc = exp_pc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int unsigned rdy, input int unsigned rsp,
                             input int unsigned ifr, input int unsigned redir);
        p_rdy = rdy; p_rsp = rsp; p_ifr = ifr; p_redir = redir;
    endtask

    initial begin
        set_knobs(100, 100, 100, 0);
        do_reset();

        // Boot stream with always-ready memory and decode.
        for (int i = 0; i < 40 && n_pop < 3; i++) step();
        check_eq("boot_three_pops", 32'(n_pop >= 3), 32'd1);

        // Decode stalled: request credit runs out at DEPTH.
        do_reset();
        set_knobs(100, 100, 0, 0);
        for (int i = 0; i < 12; i++) step();
        check_eq("stall_req_count", 32'(n_req), 32'd2);
        check_eq("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("stall_if_valid",  32'(bus.if_valid), 32'd1);

        // Redirect with two responses outstanding.
        do_reset();
        set_knobs(100, 0, 0, 0);
        for (int i = 0; i < 10 && n_req < 2; i++) step();
        check_eq("drain_setup_reqs", 32'(n_req), 32'd2);
        force_redir = 1'b1; force_tgt = 32'h100;
        step();
        n_req = 0; drain_ifv = 0;
        p_rsp = 100;
        for (int i = 0; i < 20 && n_req == 0; i++) begin
            if (bus.if_valid) drain_ifv++;
            step();
        end
        check_eq("drain_first_req", first_req_addr, 32'h100);
        check_eq("drain_if_valid",  32'(drain_ifv), 32'd0);
        p_ifr = 100; n_pop = 0;
        for (int i = 0; i < 20 && n_pop == 0; i++) step();
        check_eq("drain_first_pop", last_pop_pc, 32'h100);

        // Unaligned redirect target.
        force_redir = 1'b1; force_tgt = 32'h203;
        step();
        n_req = 0; n_pop = 0;
        for (int i = 0; i < 30 && n_pop == 0; i++) step();
        check_eq("align_first_req", first_req_addr, 32'h200);
        check_eq("align_first_pop", last_pop_pc, 32'h200);

        // Redirect coinciding with the decode handshake of pc 0x8.
        do_reset();
        set_knobs(100, 100, 100, 0);
        redir_at_en = 1'b1; redir_at_pc = 32'h8; redir_at_tgt = 32'h40;
        for (int i = 0; i < 40; i++) step();
        check_eq("hs_redir_fired", 32'(redir_at_en), 32'd0);
        check_eq("hs_pc8_pops",    32'(n_pop_8), 32'd1);
        check_eq("hs_pcC_seen",    32'(n_seen_c), 32'd0);

        // Asynchronous reset with a full buffer.
        set_knobs(100, 100, 0, 0);
        for (int i = 0; i < 12; i++) step();
        check_eq("full_if_valid",  32'(bus.if_valid), 32'd1);
        check_eq("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        do_reset();
        p_ifr = 100;
        for (int i = 0; i < 20 && n_pop == 0; i++) step();
        check_eq("restart_first_pop", last_pop_pc, RESET_PC);

        // Randomized traffic with redirects and one mid-run reset.
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 30),
                      $urandom_range(100, 20), $urandom_range(80, 0));
            if (blk == 7) do_reset();
            for (int i = 0; i < 200; i++) step();
        end

        // Forward progress once the environment is fully cooperative.
        set_knobs(100, 100, 100, 0);
        n_pop = 0;
        for (int i = 0; i < 100 && n_pop < 8; i++) step();
        check_eq("liveness_pops", 32'(n_pop >= 8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
